// File: rtl/mmu_sched_pkg.sv
// Shared types and helpers for the MMU tile scheduler.
package mmu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WT,
    ST_STREAM,
    ST_DRAIN,
    ST_WB,
    ST_DONE
  } sched_state_e;

  // Cycles for the last partial sum to leave a DEPTH x SIZE array.
  function automatic int unsigned drain_lat(input int unsigned depth, input int unsigned size);
    return depth + size - 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mmu_tile_sched_mask.sv
// mmu_blk_mask_gen: per-block bypass mask, bit di*S_LEN+si is 0 when the block is active.
module mmu_blk_mask_gen
  import mmu_sched_pkg::*;
#(
  parameter int unsigned D_LEN = 8,
  parameter int unsigned S_LEN = 8,
  parameter int unsigned DB_W  = $clog2(D_LEN + 1),
  parameter int unsigned SB_W  = $clog2(S_LEN + 1)
) (
  input  logic [DB_W-1:0]          d_blocks_i,
  input  logic [SB_W-1:0]          s_blocks_i,
  output logic [D_LEN*S_LEN-1:0]   mask_o
);

  localparam int unsigned IDX_W = max_u(1, $clog2(D_LEN * S_LEN));

  always_comb begin
    mask_o = '1;
    for (int unsigned di = 0; di < D_LEN; di++) begin
      for (int unsigned si = 0; si < S_LEN; si++) begin
        mask_o[IDX_W'(di * S_LEN + si)] = !((DB_W'(di) < d_blocks_i) && (SB_W'(si) < s_blocks_i));
      end
    end
  end

endmodule

// File: rtl/mmu_tile_sched.sv
// mmu_tile_sched: sequences one weight-load / stream / drain / write-back pass over the array.
// Optional MMU_SCHED_PERF_EN adds saturating busy-cycle and completed-pass counters.
module mmu_tile_sched
  import mmu_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned SIZE      = 32,
  parameter int unsigned MMU_BLOCK = 4,
  parameter int unsigned ROW_W     = 16,
  localparam int unsigned D_LEN    = DEPTH / MMU_BLOCK,
  localparam int unsigned S_LEN    = SIZE / MMU_BLOCK,
  localparam int unsigned DB_W     = $clog2(D_LEN + 1),
  localparam int unsigned SB_W     = $clog2(S_LEN + 1),
  localparam int unsigned MW       = D_LEN * S_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DB_W-1:0]   cfg_d_blocks,
  input  logic [SB_W-1:0]   cfg_s_blocks,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic              abort,
  output logic              mmu_control,
  output logic              wt_rd_en,
  output logic              data_rd_en,
  output logic              acc_wr_en,
  output logic [MW-1:0]     acc_sle_d,
  output logic [MW-1:0]     data_sle_s,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef MMU_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [15:0]       perf_passes
`endif
);

  localparam int unsigned     CNT_W      = max_u(ROW_W, $clog2(DEPTH + SIZE));
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_lat(DEPTH, SIZE) - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DB_W-1:0]  d_blk_q, d_blk_d;
  logic [SB_W-1:0]  s_blk_q, s_blk_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic             err_d;
  logic             mmu_control_q, wt_rd_en_q, data_rd_en_q, acc_wr_en_q;
  logic             busy_q, done_q, cfg_err_q;
  logic [CNT_W-1:0] row_last;
  logic [MW-1:0]    pass_mask;
  logic             accept;

  assign cfg_ready = (state_q == ST_IDLE);
  assign accept    = cfg_valid && cfg_ready && !abort;
  assign row_last  = CNT_W'(rows_q) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_blk_d = d_blk_q;
    s_blk_d = s_blk_q;
    rows_d  = rows_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cfg_d_blocks == '0 || cfg_s_blocks == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LOAD_WT;
            cnt_d   = '0;
            d_blk_d = (cfg_d_blocks > DB_W'(D_LEN)) ? DB_W'(D_LEN) : cfg_d_blocks;
            s_blk_d = (cfg_s_blocks > SB_W'(S_LEN)) ? SB_W'(S_LEN) : cfg_s_blocks;
            rows_d  = cfg_rows;
          end
        end
      end
      ST_LOAD_WT: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = (rows_q == '0) ? ST_DONE : ST_STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STREAM: begin
        if (cnt_q == row_last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        if (cnt_q == row_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Strobes are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      d_blk_q       <= '0;
      s_blk_q       <= '0;
      rows_q        <= '0;
      mmu_control_q <= 1'b0;
      wt_rd_en_q    <= 1'b0;
      data_rd_en_q  <= 1'b0;
      acc_wr_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d_blk_q       <= d_blk_d;
      s_blk_q       <= s_blk_d;
      rows_q        <= rows_d;
      mmu_control_q <= (state_d == ST_LOAD_WT);
      wt_rd_en_q    <= (state_d == ST_LOAD_WT);
      data_rd_en_q  <= (state_d == ST_STREAM);
      acc_wr_en_q   <= (state_d == ST_WB);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
      cfg_err_q     <= err_d;
    end
  end

  mmu_blk_mask_gen #(
    .D_LEN (D_LEN),
    .S_LEN (S_LEN),
    .DB_W  (DB_W),
    .SB_W  (SB_W)
  ) u_mask (
    .d_blocks_i (d_blk_q),
    .s_blocks_i (s_blk_q),
    .mask_o     (pass_mask)
  );

  assign mmu_control = mmu_control_q;
  assign wt_rd_en    = wt_rd_en_q;
  assign data_rd_en  = data_rd_en_q;
  assign acc_wr_en   = acc_wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign acc_sle_d   = busy_q ? pass_mask : '1;
  assign data_sle_s  = busy_q ? pass_mask : '1;

`ifdef MMU_SCHED_PERF_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_pass_q <= '0;
    end else begin
      if (busy_q && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (done_q && perf_pass_q != '1) perf_pass_q <= perf_pass_q + 16'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_passes      = perf_pass_q;
`endif

endmodule
